// File: rtl/fifo_reader.sv
// fifo_reader: turns a synchronous FIFO read port (rd_en/empty, one-cycle read
// latency) into a valid/ready stream through a two-entry skid buffer.
//
// Optional feature: define FIFO_READER_CNT_EN to add the xfer_count port and
// its transfer counter. Without it the port and counter are absent.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  read request to the upstream FIFO (combinational)
//   m_data      downstream data, oldest buffered word
//   m_valid     downstream valid
//   m_ready     downstream ready
//   xfer_count  completed downstream transfers, wraps at 16 bits (optional)
module fifo_reader #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic [Width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    localparam int unsigned CreditW = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e               occ;
    logic               inflight;
    logic [Width-1:0]   buf1;
    logic               xfer_c;
    logic [CreditW-1:0] credit_c;

    // Downstream handshake; m_valid is zero whenever the buffer is empty.
    assign xfer_c = m_valid && m_ready;

    // Slots committed after this edge: buffered + in flight - leaving now.
    // xfer_c implies occ != EMPTY, so the subtraction never underflows.
    assign credit_c = CreditW'(occ) + CreditW'(inflight) - CreditW'(xfer_c);

    // Only request a word if there is guaranteed room to capture it.
    assign fifo_rd_en = reset && !fifo_empty && (credit_c < CreditW'(2));

    // Occupancy state machine and skid buffer; m_data is the head slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            buf1     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({inflight, xfer_c})
                2'b10: begin
                    // Capture only: fill the next free slot.
                    if (occ == EMPTY) begin
                        m_data  <= fifo_data;
                        m_valid <= 1'b1;
                        occ     <= ONE;
                    end else begin
                        buf1 <= fifo_data;
                        occ  <= TWO;
                    end
                end
                2'b01: begin
                    // Transfer only: advance the second slot to the head.
                    if (occ == TWO) begin
                        m_data <= buf1;
                        occ    <= ONE;
                    end else begin
                        m_valid <= 1'b0;
                        occ     <= EMPTY;
                    end
                end
                2'b11: begin
                    // Capture and transfer: occupancy unchanged, shift by one.
                    if (occ == TWO) begin
                        m_data <= buf1;
                        buf1   <= fifo_data;
                    end else begin
                        m_data <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_READER_CNT_EN
    // Transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_count <= 16'd0;
        end else if (xfer_c) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a behavioural
// one-cycle-latency upstream FIFO.
module tb_fifo_reader;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_data = '0;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]  xfer_count;
`endif

    logic [W-1:0] mem [32];
    int           wr_cnt = 0;
    int           rd_ptr = 0;
    int           reads = 0;
    int           xfers = 0;
    logic         fifo_clr = 1'b0;
    logic         stream = 1'b0;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q [$];

    logic [W-1:0] v26 [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D,
                               8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};

    fifo_reader #(.Width(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO: in stream mode it is never empty and returns its read index.
    assign fifo_empty = stream ? 1'b0 : (rd_ptr == wr_cnt);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr    <= 0;
            reads     <= 0;
            xfers     <= 0;
            fifo_data <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_data <= stream ? W'(rd_ptr) : mem[rd_ptr[4:0]];
                rd_ptr    <= rd_ptr + 1;
                reads     <= reads + 1;
            end
            if (m_valid && m_ready) xfers <= xfers + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [W-1:0] v);
        mem[wr_cnt[4:0]] = v;
        wr_cnt++;
    endtask

    // Hold reset and empty the FIFO model and monitor counters.
    task automatic start_test();
        reset    = 1'b0;
        m_ready  = 1'b0;
        stream   = 1'b0;
        wr_cnt   = 0;
        fifo_clr = 1'b1;
        tick();
        tick();
        fifo_clr = 1'b0;
    endtask

    // Collect n transfers against exp_q within a cycle budget.
    task automatic drain(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            if (m_valid && m_ready) begin
                check("drain_data", 32'(m_data), 32'(exp_q.pop_front()));
                got++;
            end
            tick();
            cyc++;
        end
        check("drain_count", got, n);
    endtask

    initial begin
        @(negedge clk);

        // Reset held with a loaded FIFO.
        start_test();
        for (int i = 0; i < 10; i++) push_word(v26[i]);
        tick();
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
`ifdef FIFO_READER_CNT_EN
        check("rst_count", 32'(xfer_count), 32'd0);
`endif

        // Streaming: ten words, one per cycle, in order.
        m_ready = 1'b1;
        reset   = 1'b1;
        #1;
        check("rd_en_at_release", 32'(fifo_rd_en), 32'd1);
        tick();
        check("valid_edge0", 32'(m_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(v26[i]));
        end
        tick();
        check("stream_valid_end", 32'(m_valid), 32'd0);
        check("stream_xfers", xfers, 32'd10);
        check("stream_reads", reads, 32'd10);
`ifdef FIFO_READER_CNT_EN
        check("stream_count", 32'(xfer_count), 32'd10);
`endif

        // Backpressure: two words held, reads stop, then drain in order.
        start_test();
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        push_word(8'h44); push_word(8'h55);
        reset = 1'b1;
        tick();
        tick();
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h11);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_data_stable", 32'(m_data), 32'h11);
        end
        check("bp_reads", reads, 32'd2);
        check("bp_rd_en_off", 32'(fifo_rd_en), 32'd0);
        check("bp_xfers", xfers, 32'd0);
        m_ready = 1'b1;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drain(5, 20);
        check("bp_valid_end", 32'(m_valid), 32'd0);
        check("bp_xfers_end", xfers, 32'd5);

        // Single word, FIFO empties while the read is in flight.
        start_test();
        push_word(8'h5A);
        m_ready = 1'b1;
        reset   = 1'b1;
        #1;
        check("one_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        check("one_rd_en_empty", 32'(fifo_rd_en), 32'd0);
        check("one_valid_e0", 32'(m_valid), 32'd0);
        tick();
        check("one_valid", 32'(m_valid), 32'd1);
        check("one_data", 32'(m_data), 32'h5A);
        tick();
        check("one_valid_drop", 32'(m_valid), 32'd0);
        tick();
        tick();
        check("one_xfers", xfers, 32'd1);
        check("one_reads", reads, 32'd1);
        check("one_valid_idle", 32'(m_valid), 32'd0);

        // Reset with two buffered words discards them.
        start_test();
        push_word(8'hA1); push_word(8'hB2); push_word(8'hC3); push_word(8'hD4);
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("rr_valid", 32'(m_valid), 32'd1);
        check("rr_data", 32'(m_data), 32'hA1);
        check("rr_rd_en_full", 32'(fifo_rd_en), 32'd0);
        reset = 1'b0;
        #1;
        check("rr_rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
        tick();
        check("rr_valid_after", 32'(m_valid), 32'd0);
        check("rr_data_after", 32'(m_data), 32'd0);
        wr_cnt   = 0;
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        m_ready  = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_post_valid", 32'(m_valid), 32'd0);
            check("rr_post_data", 32'(m_data), 32'd0);
        end
        check("rr_post_xfers", xfers, 32'd0);

`ifdef FIFO_READER_CNT_EN
        // Counter wrap after 65536 transfers.
        begin
            int cyc = 0;
            start_test();
            stream  = 1'b1;
            m_ready = 1'b1;
            reset   = 1'b1;
            while (xfer_count != 16'hFFFF && cyc < 70000) begin
                tick();
                cyc++;
            end
            check("cnt_ffff", 32'(xfer_count), 32'hFFFF);
            tick();
            check("cnt_wrap", 32'(xfer_count), 32'h0000);
            stream  = 1'b0;
            m_ready = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
